// File: rtl/ball_edge_detector.sv
// Two-axis ball edge detector: follows the raster from line/frame strobes, latches edge
// touches and commits X/Y directions at frame end. Define BOUNCE_COUNTER_EN to build o_BounceCnt.
module ball_edge_detector #(
  parameter int   H_VISIBLE   = 640,
  parameter int   V_VISIBLE   = 480,
  parameter int   COORD_W     = 10,
  parameter int   EDGE_MARGIN = 0,
  parameter logic XDIR_INIT   = 1'b0,
  parameter logic YDIR_INIT   = 1'b0,
  parameter int   CNT_W       = 8
) (
  input  logic             i_Clk,
  input  logic             i_Reset,
  input  logic             i_HReset,
  input  logic             i_VReset,
  input  logic             i_HBlank,
  input  logic             i_VBlank,
  input  logic             i_Ball,
  output logic             o_XDir,
  output logic             o_YDir,
  output logic             o_Bounce,
  output logic [CNT_W-1:0] o_BounceCnt
);

  localparam logic [COORD_W-1:0] LEFT_LIM   = COORD_W'(EDGE_MARGIN);
  localparam logic [COORD_W-1:0] RIGHT_LIM  = COORD_W'(H_VISIBLE - 1 - EDGE_MARGIN);
  localparam logic [COORD_W-1:0] TOP_LIM    = COORD_W'(EDGE_MARGIN);
  localparam logic [COORD_W-1:0] BOTTOM_LIM = COORD_W'(V_VISIBLE - 1 - EDGE_MARGIN);

  typedef struct packed {
    logic l;
    logic r;
    logic t;
    logic b;
  } edge_flags_t;

  logic [COORD_W-1:0] col_q, col_d;
  logic [COORD_W-1:0] row_q, row_d;
  edge_flags_t        flags_q, flags_d;
  edge_flags_t        touch;
  logic               xdir_q, xdir_d;
  logic               ydir_q, ydir_d;
  logic               bounce_q, bounce_d;
  logic               visible;
  logic               commit;
  logic               x_flip;
  logic               y_flip;

  assign visible = ~i_HBlank & ~i_VBlank;
  assign commit  = i_VReset;

  // NOTE: every signal driven here gets a default first so no path leaves it unassigned
  // and no latch is inferred.
  always_comb begin
    col_d = col_q;
    if (i_HReset) begin
      col_d = '0;
    end else if (visible) begin
      col_d = col_q + COORD_W'(1);
    end

    row_d = row_q;
    if (i_VReset) begin
      row_d = '0;
    end else if (i_HReset && !i_VBlank) begin
      row_d = row_q + COORD_W'(1);
    end
  end

  always_comb begin
    touch = '0;
    if (visible && i_Ball) begin
      touch.l = (col_q <= LEFT_LIM);
      touch.r = (col_q >= RIGHT_LIM);
      touch.t = (row_q <= TOP_LIM);
      touch.b = (row_q >= BOTTOM_LIM);
    end
  end

  // A touch on one edge only flips toward the opposite side; a ball spanning both
  // edges, or one already moving away from the touched edge, keeps its direction.
  always_comb begin
    x_flip = (flags_q.l & ~flags_q.r & ~xdir_q) | (flags_q.r & ~flags_q.l & xdir_q);
    y_flip = (flags_q.t & ~flags_q.b & ~ydir_q) | (flags_q.b & ~flags_q.t & ydir_q);

    flags_d  = flags_q | touch;
    xdir_d   = xdir_q;
    ydir_d   = ydir_q;
    bounce_d = 1'b0;
    if (commit) begin
      flags_d  = '0;
      xdir_d   = xdir_q ^ x_flip;
      ydir_d   = ydir_q ^ y_flip;
      bounce_d = x_flip | y_flip;
    end
  end

  // NOTE: state registers use non-blocking assignments so every register samples the
  // pre-edge values, independent of statement order.
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      col_q    <= '0;
      row_q    <= '0;
      flags_q  <= '0;
      xdir_q   <= XDIR_INIT;
      ydir_q   <= YDIR_INIT;
      bounce_q <= 1'b0;
    end else begin
      col_q    <= col_d;
      row_q    <= row_d;
      flags_q  <= flags_d;
      xdir_q   <= xdir_d;
      ydir_q   <= ydir_d;
      bounce_q <= bounce_d;
    end
  end

  assign o_XDir   = xdir_q;
  assign o_YDir   = ydir_q;
  assign o_Bounce = bounce_q;

`ifdef BOUNCE_COUNTER_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Counts alongside the pulse so the new value appears in the same cycle as o_Bounce.
  always_comb begin
    cnt_d = cnt_q;
    if (bounce_d && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_BounceCnt = cnt_q;
`else
  assign o_BounceCnt = '0;
`endif

endmodule

// File: tb/tb_ball_edge_detector.sv
// Bench for ball_edge_detector: two instances (margin 0 / margin 2) on a small raster,
// a geometric per-frame model pushes expected commit results that are popped after i_VReset.
module tb_ball_edge_detector;

  localparam int H_VIS   = 16;
  localparam int V_VIS   = 12;
  localparam int H_TOT   = H_VIS + 4;
  localparam int V_TOT   = V_VIS + 2;
  localparam int COORD_W = 5;

  logic i_Clk = 1'b0;
  logic i_Reset, i_HReset, i_VReset, i_HBlank, i_VBlank, i_Ball;
  logic xdir_a, ydir_a, bnc_a, xdir_b, ydir_b, bnc_b;
  logic [1:0] cnt_a;
  logic [7:0] cnt_b;

  always #5 i_Clk = ~i_Clk;

  ball_edge_detector #(
    .H_VISIBLE(H_VIS), .V_VISIBLE(V_VIS), .COORD_W(COORD_W), .EDGE_MARGIN(0),
    .XDIR_INIT(1'b1), .YDIR_INIT(1'b0), .CNT_W(2)
  ) dut_a (
    .i_Clk(i_Clk), .i_Reset(i_Reset), .i_HReset(i_HReset), .i_VReset(i_VReset),
    .i_HBlank(i_HBlank), .i_VBlank(i_VBlank), .i_Ball(i_Ball),
    .o_XDir(xdir_a), .o_YDir(ydir_a), .o_Bounce(bnc_a), .o_BounceCnt(cnt_a)
  );

  ball_edge_detector #(
    .H_VISIBLE(H_VIS), .V_VISIBLE(V_VIS), .COORD_W(COORD_W), .EDGE_MARGIN(2),
    .XDIR_INIT(1'b0), .YDIR_INIT(1'b0), .CNT_W(8)
  ) dut_b (
    .i_Clk(i_Clk), .i_Reset(i_Reset), .i_HReset(i_HReset), .i_VReset(i_VReset),
    .i_HBlank(i_HBlank), .i_VBlank(i_VBlank), .i_Ball(i_Ball),
    .o_XDir(xdir_b), .o_YDir(ydir_b), .o_Bounce(bnc_b), .o_BounceCnt(cnt_b)
  );

  typedef struct {
    logic x[2];
    logic y[2];
    logic b[2];
    int   c[2];
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  // Model state per instance (index 0 = dut_a, 1 = dut_b).
  logic m_x[2];
  logic m_y[2];
  int   m_c[2];
  int   margin[2] = '{0, 2};
  int   cmax[2]   = '{3, 255};
  logic xinit[2]  = '{1'b1, 1'b0};
  logic yinit[2]  = '{1'b0, 1'b0};

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic logic new_dir(input logic lo, input logic hi, input logic dir);
    if (lo && !hi) return 1'b1;
    if (hi && !lo) return 1'b0;
    return dir;
  endfunction

  function automatic int exp_cnt(input int d);
`ifdef BOUNCE_COUNTER_EN
    return m_c[d];
`else
    return 0 * d;
`endif
  endfunction

  task automatic tick();
    @(posedge i_Clk);
    #1;
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_x[d] = xinit[d];
      m_y[d] = yinit[d];
      m_c[d] = 0;
    end
  endtask

  task automatic check_outputs(input string tag, input exp_t e);
    check({tag, " xdir_a"}, int'(xdir_a), int'(e.x[0]));
    check({tag, " ydir_a"}, int'(ydir_a), int'(e.y[0]));
    check({tag, " bounce_a"}, int'(bnc_a), int'(e.b[0]));
    check({tag, " cnt_a"}, int'(cnt_a), e.c[0]);
    check({tag, " xdir_b"}, int'(xdir_b), int'(e.x[1]));
    check({tag, " ydir_b"}, int'(ydir_b), int'(e.y[1]));
    check({tag, " bounce_b"}, int'(bnc_b), int'(e.b[1]));
    check({tag, " cnt_b"}, int'(cnt_b), e.c[1]);
  endtask

  // One frame with an optional rectangular ball [x0..x1]x[y0..y1]. With rst_row >= 0,
  // i_Reset pulses at the end of that line (ball rows must lie before it).
  task automatic run_frame(input string tag, input bit en, input int x0, input int x1,
                           input int y0, input int y1, input int rst_row = -1);
    exp_t e, pre, got;
    for (int d = 0; d < 2; d++) begin
      logic lo_x, hi_x, lo_y, hi_y, nx, ny;
      pre.x[d] = m_x[d];
      pre.y[d] = m_y[d];
      pre.b[d] = 1'b0;
      pre.c[d] = exp_cnt(d);
      lo_x = en && (x0 <= margin[d]);
      hi_x = en && (x1 >= H_VIS - 1 - margin[d]);
      lo_y = en && (y0 <= margin[d]);
      hi_y = en && (y1 >= V_VIS - 1 - margin[d]);
      if (rst_row >= 0) begin
        m_x[d] = xinit[d];
        m_y[d] = yinit[d];
        m_c[d] = 0;
        e.b[d] = 1'b0;
      end else begin
        nx = new_dir(lo_x, hi_x, m_x[d]);
        ny = new_dir(lo_y, hi_y, m_y[d]);
        e.b[d] = (nx != m_x[d]) || (ny != m_y[d]);
        if (e.b[d] && m_c[d] < cmax[d]) m_c[d]++;
        m_x[d] = nx;
        m_y[d] = ny;
      end
      e.x[d] = m_x[d];
      e.y[d] = m_y[d];
      e.c[d] = exp_cnt(d);
    end
    sb.push_back(e);

    for (int r = 0; r < V_TOT; r++) begin
      for (int c = 0; c < H_TOT; c++) begin
        i_HBlank = (c >= H_VIS);
        i_VBlank = (r >= V_VIS);
        i_HReset = (c == H_TOT - 1);
        i_VReset = (c == H_TOT - 1) && (r == V_TOT - 1);
        i_Ball   = en && (c >= x0) && (c <= x1) && (r >= y0) && (r <= y1);
        i_Reset  = (r == rst_row) && (c == H_TOT - 1);
        tick();
        if (rst_row < 0 && r == V_VIS / 2 && c == 0) check_outputs({tag, " mid"}, pre);
      end
    end

    if (sb.size() == 0) begin
      check({tag, " scoreboard empty"}, 1, 0);
    end else begin
      got = sb.pop_front();
      check_outputs({tag, " commit"}, got);
    end

    // Idle blanking cycle: pulse must be gone, directions and count unchanged.
    i_HReset = 1'b0; i_VReset = 1'b0; i_Ball = 1'b0; i_Reset = 1'b0;
    i_HBlank = 1'b1; i_VBlank = 1'b1;
    tick();
    check({tag, " pulse end a"}, int'(bnc_a), 0);
    check({tag, " pulse end b"}, int'(bnc_b), 0);
    check({tag, " hold xdir_a"}, int'(xdir_a), int'(m_x[0]));
    check({tag, " hold cnt_b"}, int'(cnt_b), exp_cnt(1));
  endtask

  initial begin
    exp_t rst_e;
    i_Reset = 1'b1; i_HReset = 1'b0; i_VReset = 1'b0;
    i_HBlank = 1'b1; i_VBlank = 1'b1; i_Ball = 1'b0;
    tick();
    tick();
    i_Reset = 1'b0;
    model_reset();
    for (int d = 0; d < 2; d++) begin
      rst_e.x[d] = xinit[d];
      rst_e.y[d] = yinit[d];
      rst_e.b[d] = 1'b0;
      rst_e.c[d] = 0;
    end
    check_outputs("reset", rst_e);

    run_frame("no_ball",      1'b0, 0, 0, 0, 0);
    run_frame("left_col0",    1'b1, 0, 1, 3, 5);
    run_frame("span_x",       1'b1, 0, H_VIS - 1, 4, 5);
    run_frame("top_left",     1'b1, 0, 1, 0, 1);
    run_frame("bottom_right", 1'b1, H_VIS - 2, H_VIS - 1, V_VIS - 2, V_VIS - 1);
    run_frame("left_col3",    1'b1, 3, 4, 5, 6);
    run_frame("left_col2",    1'b1, 2, 3, 5, 6);
    run_frame("mid_reset",    1'b1, 0, 1, 2, 3, 6);
    for (int i = 0; i < 5; i++) begin
      if (i % 2 == 0) run_frame($sformatf("sat_right%0d", i), 1'b1, H_VIS - 2, H_VIS - 1, 5, 6);
      else            run_frame($sformatf("sat_left%0d", i),  1'b1, 0, 1, 5, 6);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
